// File: rtl/cla_seq_pkg.sv
// rtl/cla_seq_pkg.sv - shared slice width, FSM encoding and sizing helper for the slice sequencer
package cla_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice index width; a single-slice build still needs a 1-bit index register.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/cla.sv
// rtl/cla.sv - 4-bit carry-lookahead adder slice
module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is formed directly from generate/propagate terms, no ripple.
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);
    assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign s = p ^ c;

endmodule

// File: rtl/cla_slice_sequencer.sv
// rtl/cla_slice_sequencer.sv - multi-cycle wide adder reusing one 4-bit CLA per slice
module cla_slice_sequencer
    import cla_seq_pkg::*;
#(
    parameter int NSLICE = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SLICE_W*NSLICE-1:0] a,
    input  logic [SLICE_W*NSLICE-1:0] b,
    input  logic                      c_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SLICE_W*NSLICE-1:0] s,
    output logic                      c_out,
    output logic                      ovf
);

    localparam int W     = SLICE_W * NSLICE;
    localparam int IDX_W = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t state;
    state_t state_nxt;

    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       result;
    logic [IDX_W-1:0]   idx;
    logic               carry;

    logic [SLICE_W-1:0] a_sl   [NSLICE];
    logic [SLICE_W-1:0] b_sl   [NSLICE];
    logic [SLICE_W-1:0] res_sl [NSLICE];

    logic [SLICE_W-1:0] slice_s;
    logic               slice_c;
    logic               accept;
    logic               step;

    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
        assign a_sl[g] = a_q[g*SLICE_W +: SLICE_W];
        assign b_sl[g] = b_q[g*SLICE_W +: SLICE_W];
        assign result[g*SLICE_W +: SLICE_W] = res_sl[g];
    end

    cla u_cla (
        .a     (a_sl[idx]),
        .b     (b_sl[idx]),
        .c_in  (carry),
        .s     (slice_s),
        .c_out (slice_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ADD;
                end
            end
            ADD: begin
                step = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are captured once, so input activity after accept cannot disturb the sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            for (int i = 0; i < NSLICE; i++) begin
                res_sl[i] <= '0;
            end
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= '0;
            carry <= c_in;
        end else if (step) begin
            res_sl[idx] <= slice_s;
            carry       <= slice_c;
            if (idx != LAST_IDX) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign s     = result;
    assign c_out = carry;
    assign ovf   = (a_q[W-1] == b_q[W-1]) && (result[W-1] != a_q[W-1]);

endmodule
